// File: rtl/fpu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fpu_arbiter_if
// Desc     : Requester, response and fpu-side signals of the fpu arbiter.
// Revision : 1.0
// ============================================================================
interface fpu_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [2*NUM_REQ-1:0]  req_opcode;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_z;
    logic [2:0]            rsp_error;
    logic                  rsp_timeout;
    logic                  busy;

    logic                  fpu_rst;
    logic                  fpu_start;
    logic [1:0]            fpu_opcode;
    logic [31:0]           fpu_a;
    logic [31:0]           fpu_b;
    logic [31:0]           fpu_z;
    logic [2:0]            fpu_error;
    logic                  fpu_done;

    modport master (
        input  req_valid, req_opcode, req_a, req_b, rsp_ready,
               fpu_z, fpu_error, fpu_done,
        output req_ready, rsp_valid, rsp_id, rsp_z, rsp_error, rsp_timeout,
               busy, fpu_rst, fpu_start, fpu_opcode, fpu_a, fpu_b
    );

    modport slave (
        output req_valid, req_opcode, req_a, req_b, rsp_ready,
               fpu_z, fpu_error, fpu_done,
        input  req_ready, rsp_valid, rsp_id, rsp_z, rsp_error, rsp_timeout,
               busy, fpu_rst, fpu_start, fpu_opcode, fpu_a, fpu_b
    );
endinterface
`default_nettype wire

// File: rtl/fpu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fpu_arbiter
// Desc     : Round-robin arbiter/sequencer sharing one fpu among NUM_REQ clients.
// Revision : 1.0
// ============================================================================
module fpu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  wire           clk,
    input  wire           rst_n,
    fpu_arbiter_if.master bus
);

    localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CLR  = 2'd1,
        S_RUN  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t          r_state;
    logic [ID_W-1:0] r_last;
    logic [15:0]     r_cnt;
    logic            r_fpu_rst;
    logic            r_fpu_start;
    logic [1:0]      r_fpu_opcode;
    logic [31:0]     r_fpu_a;
    logic [31:0]     r_fpu_b;
    logic            r_rsp_valid;
    logic [ID_W-1:0] r_rsp_id;
    logic [31:0]     r_rsp_z;
    logic [2:0]      r_rsp_error;
    logic            r_rsp_timeout;
    logic            r_busy;

    logic            w_grant_valid;
    logic [ID_W-1:0] w_grant_idx;
    logic [1:0]      w_sel_op;
    logic [31:0]     w_sel_a;
    logic [31:0]     w_sel_b;
    int              w_dist;
    int              w_best;

    // Pick the valid requester closest after r_last in circular order.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        w_sel_op      = '0;
        w_sel_a       = '0;
        w_sel_b       = '0;
        w_best        = NUM_REQ;
        w_dist        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = (i + NUM_REQ - 1 - int'(r_last)) % NUM_REQ;
            if (bus.req_valid[i] && (w_dist < w_best)) begin
                w_best        = w_dist;
                w_grant_valid = 1'b1;
                w_grant_idx   = ID_W'(i);
                w_sel_op      = bus.req_opcode[2*i +: 2];
                w_sel_a       = bus.req_a[32*i +: 32];
                w_sel_b       = bus.req_b[32*i +: 32];
            end
        end
    end

    assign bus.req_ready = ((r_state == S_IDLE) && w_grant_valid)
                         ? (NUM_REQ'(1) << w_grant_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_last        <= ID_W'(NUM_REQ - 1);
            r_cnt         <= '0;
            r_fpu_rst     <= 1'b1;
            r_fpu_start   <= 1'b0;
            r_fpu_opcode  <= '0;
            r_fpu_a       <= '0;
            r_fpu_b       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_id      <= '0;
            r_rsp_z       <= '0;
            r_rsp_error   <= '0;
            r_rsp_timeout <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_fpu_rst <= 1'b0;
                    if (w_grant_valid) begin
                        r_fpu_opcode <= w_sel_op;
                        r_fpu_a      <= w_sel_a;
                        r_fpu_b      <= w_sel_b;
                        r_rsp_id     <= w_grant_idx;
                        r_last       <= w_grant_idx;
                        r_fpu_rst    <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= S_CLR;
                    end
                end
                S_CLR: begin
                    r_fpu_rst   <= 1'b0;
                    r_fpu_start <= 1'b1;
                    r_cnt       <= '0;
                    r_state     <= S_RUN;
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 16'd1;
                    // A late done still wins over the timeout in the same cycle.
                    if (bus.fpu_done) begin
                        r_rsp_z       <= bus.fpu_z;
                        r_rsp_error   <= bus.fpu_error;
                        r_rsp_timeout <= 1'b0;
                        r_fpu_start   <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= S_RESP;
                    end else if (r_cnt == c_TIMEOUT_LAST) begin
                        r_rsp_z       <= '0;
                        r_rsp_error   <= '0;
                        r_rsp_timeout <= 1'b1;
                        r_fpu_start   <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.fpu_rst     = r_fpu_rst;
    assign bus.fpu_start   = r_fpu_start;
    assign bus.fpu_opcode  = r_fpu_opcode;
    assign bus.fpu_a       = r_fpu_a;
    assign bus.fpu_b       = r_fpu_b;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_id      = r_rsp_id;
    assign bus.rsp_z       = r_rsp_z;
    assign bus.rsp_error   = r_rsp_error;
    assign bus.rsp_timeout = r_rsp_timeout;
    assign bus.busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fpu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_arbiter
// Desc     : Directed self-checking bench for fpu_arbiter with a cycle model.
// Revision : 1.0
// ============================================================================
module tb_fpu_arbiter;

    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 8;
    localparam int ID_W    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fpu_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    fpu_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT), .ID_W(ID_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural fpu: done rises fpu_lat start-cycles after clear, held until cleared.
    int          fpu_lat     = 1;
    bit          fpu_hang    = 1'b0;
    logic [31:0] fpu_z_val   = '0;
    logic [2:0]  fpu_err_val = '0;
    int          fpu_cnt     = 0;

    assign bus.fpu_z     = fpu_z_val;
    assign bus.fpu_error = fpu_err_val;

    always @(posedge clk) begin
        if (bus.fpu_rst) begin
            fpu_cnt      <= 0;
            bus.fpu_done <= 1'b0;
        end else if (bus.fpu_start && !fpu_hang) begin
            fpu_cnt <= fpu_cnt + 1;
            if (fpu_cnt + 1 >= fpu_lat) bus.fpu_done <= 1'b1;
        end
    end

    // Reference model: one op record plus its age in cycles since acceptance.
    bit              m_active = 1'b0;
    bit              m_resp   = 1'b0;
    bit              m_post   = 1'b0;
    int              m_age    = 0;
    logic [ID_W-1:0] m_last   = ID_W'(NUM_REQ - 1);
    logic [ID_W-1:0] m_id     = '0;
    logic [1:0]      m_op     = '0;
    logic [31:0]     m_a      = '0;
    logic [31:0]     m_b      = '0;
    logic [31:0]     m_z      = '0;
    logic [2:0]      m_err    = '0;
    bit              m_to     = 1'b0;
    int              grant_log[$];

    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
        for (int k = 1; k <= NUM_REQ; k++)
            if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        return -1;
    endfunction

    always @(negedge clk) begin : p_model
        logic [NUM_REQ-1:0] exp_ready;
        int                 pick;
        if (rst_n) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (bus.req_valid[i] && bus.req_ready[i]) grant_log.push_back(i);
        end
        if (!rst_n) begin
            chk("rst_busy",        bus.busy,        1'b0);
            chk("rst_rsp_valid",   bus.rsp_valid,   1'b0);
            chk("rst_fpu_rst",     bus.fpu_rst,     1'b1);
            chk("rst_fpu_start",   bus.fpu_start,   1'b0);
            chk("rst_rsp_id",      bus.rsp_id,      '0);
            chk("rst_rsp_z",       bus.rsp_z,       '0);
            chk("rst_rsp_error",   bus.rsp_error,   '0);
            chk("rst_rsp_timeout", bus.rsp_timeout, 1'b0);
            chk("rst_fpu_ops",     {bus.fpu_opcode, bus.fpu_a, bus.fpu_b}, '0);
            m_active = 1'b0;
            m_resp   = 1'b0;
            m_post   = 1'b1;
            m_last   = ID_W'(NUM_REQ - 1);
        end else begin
            pick      = m_active ? -1 : rr_pick(bus.req_valid, int'(m_last));
            exp_ready = (pick >= 0) ? (NUM_REQ'(1) << pick) : '0;
            chk("req_ready", bus.req_ready, exp_ready);
            chk("busy",      bus.busy,      m_active);
            chk("rsp_valid", bus.rsp_valid, m_resp);
            chk("fpu_rst",   bus.fpu_rst,   m_active ? (!m_resp && m_age == 1) : m_post);
            chk("fpu_start", bus.fpu_start, m_active && !m_resp && m_age >= 2);
            if (m_active) begin
                chk("fpu_opcode", bus.fpu_opcode, m_op);
                chk("fpu_a",      bus.fpu_a,      m_a);
                chk("fpu_b",      bus.fpu_b,      m_b);
            end
            if (m_resp) begin
                chk("rsp_id",      bus.rsp_id,      m_id);
                chk("rsp_z",       bus.rsp_z,       m_z);
                chk("rsp_error",   bus.rsp_error,   m_err);
                chk("rsp_timeout", bus.rsp_timeout, m_to);
            end
            m_post = 1'b0;
            if (!m_active) begin
                if (pick >= 0) begin
                    m_active = 1'b1;
                    m_age    = 1;
                    m_id     = ID_W'(pick);
                    m_last   = ID_W'(pick);
                    m_op     = bus.req_opcode[2*pick +: 2];
                    m_a      = bus.req_a[32*pick +: 32];
                    m_b      = bus.req_b[32*pick +: 32];
                end
            end else if (!m_resp) begin
                if (m_age >= 2) begin
                    if (bus.fpu_done) begin
                        m_resp = 1'b1; m_z = bus.fpu_z; m_err = bus.fpu_error; m_to = 1'b0;
                    end else if (m_age - 2 == TIMEOUT - 1) begin
                        m_resp = 1'b1; m_z = '0; m_err = '0; m_to = 1'b1;
                    end
                end
                m_age++;
            end else if (bus.rsp_ready) begin
                m_active = 1'b0;
                m_resp   = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns in cycle 1 after the accepting edge.
    task automatic send(input int id, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bit ok;
        ok = 1'b0;
        bus.req_opcode[2*id +: 2] = op;
        bus.req_a[32*id +: 32]    = a;
        bus.req_b[32*id +: 32]    = b;
        bus.req_valid[id]         = 1'b1;
        for (int t = 0; t < 64; t++) begin
            #1;
            ok = bus.req_ready[id];
            tick();
            if (ok) break;
        end
        bus.req_valid[id] = 1'b0;
        chk("accept_bound", ok, 1'b1);
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 1;
        while (!bus.rsp_valid && cyc < 400) begin
            tick();
            cyc++;
        end
        chk("rsp_bound", bus.rsp_valid, 1'b1);
    endtask

    initial begin
        int cyc;
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        bus.req_valid  = '0;
        bus.req_opcode = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.rsp_ready  = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_fpu_rst", bus.fpu_rst, 1'b1);
        chk("reset_busy",    bus.busy,    1'b0);
        rst_n = 1'b1;
        tick();

        // Single op: 1.0 + 2.0
        fpu_lat = 3; fpu_z_val = 32'h4040_0000; fpu_err_val = 3'b000;
        send(0, 2'b00, 32'h3F80_0000, 32'h4000_0000);
        wait_rsp(cyc);
        chk("single_latency", cyc, 6);
        chk("single_id",      bus.rsp_id, 0);
        chk("single_z",       bus.rsp_z, 32'h4040_0000);
        chk("single_err",     bus.rsp_error, 3'b000);
        chk("single_to",      bus.rsp_timeout, 1'b0);
        chk("single_fpu_a",   bus.fpu_a, 32'h3F80_0000);
        tick();

        // Error passthrough from requester 2
        fpu_lat = 2; fpu_z_val = 32'h7FC0_0000; fpu_err_val = 3'b100;
        send(2, 2'b11, 32'h7F80_0000, 32'hFF80_0000);
        wait_rsp(cyc);
        chk("err_latency", cyc, 5);
        chk("err_id",      bus.rsp_id, 2);
        chk("err_z",       bus.rsp_z, 32'h7FC0_0000);
        chk("err_err",     bus.rsp_error, 3'b100);
        tick();

        // Timeout, then a normal op
        fpu_hang = 1'b1; fpu_err_val = 3'b000;
        send(1, 2'b01, 32'h4100_0000, 32'h4200_0000);
        wait_rsp(cyc);
        chk("to_latency", cyc, 10);
        chk("to_flag",    bus.rsp_timeout, 1'b1);
        chk("to_z",       bus.rsp_z, 32'h0);
        chk("to_id",      bus.rsp_id, 1);
        tick();
        fpu_hang = 1'b0; fpu_lat = 2; fpu_z_val = 32'h1234_5678;
        send(3, 2'b10, 32'h3F00_0000, 32'h3E80_0000);
        wait_rsp(cyc);
        chk("after_to_latency", cyc, 5);
        chk("after_to_flag",    bus.rsp_timeout, 1'b0);
        chk("after_to_z",       bus.rsp_z, 32'h1234_5678);
        tick();

        // Response backpressure with requester 2 waiting
        fpu_lat = 1; fpu_z_val = 32'hCAFE_F00D;
        bus.rsp_ready = 1'b0;
        bus.req_opcode[5:4] = 2'b01;
        bus.req_a[95:64]    = 32'h0000_00A2;
        bus.req_b[95:64]    = 32'h0000_00B2;
        bus.req_valid[2]    = 1'b1;
        send(0, 2'b10, 32'h0000_00A0, 32'h0000_00B0);
        wait_rsp(cyc);
        chk("bp_latency", cyc, 4);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", bus.rsp_valid, 1'b1);
            chk("bp_z",     bus.rsp_z, 32'hCAFE_F00D);
            chk("bp_ready", bus.req_ready, 4'b0000);
            chk("bp_busy",  bus.busy, 1'b1);
        end
        bus.rsp_ready = 1'b1;
        tick();
        chk("bp_release_busy",  bus.busy, 1'b0);
        chk("bp_release_grant", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid[2] = 1'b0;
        wait_rsp(cyc);
        chk("bp_next_latency", cyc, 4);
        chk("bp_next_id",      bus.rsp_id, 2);
        tick();

        // Reset in the fourth RUN cycle
        fpu_hang = 1'b1;
        send(1, 2'b00, 32'h1111_1111, 32'h2222_2222);
        repeat (4) tick();
        chk("midrst_pre_start", bus.fpu_start, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("midrst_fpu_rst",   bus.fpu_rst, 1'b1);
        chk("midrst_busy",      bus.busy, 1'b0);
        chk("midrst_start",     bus.fpu_start, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        fpu_hang = 1'b0; fpu_lat = 1; fpu_z_val = 32'h0BAD_BEEF;
        tick();

        // Round-robin with every requester holding valid
        grant_log.delete();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_opcode[2*i +: 2] = 2'(i);
            bus.req_a[32*i +: 32]    = 32'h1000 + 32'(i);
            bus.req_b[32*i +: 32]    = 32'h2000 + 32'(i);
        end
        bus.req_valid = '1;
        for (int t = 0; t < 200 && grant_log.size() < 5; t++) tick();
        bus.req_valid = '0;
        for (int t = 0; t < 50 && bus.busy; t++) tick();
        chk("rr_idle",  bus.busy, 1'b0);
        chk("rr_count", grant_log.size(), 5);
        for (int i = 0; i < 5; i++)
            chk("rr_order", (i < grant_log.size()) ? grant_log[i] : -1, exp_order[i]);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
